vga_fb_scanout: RTL and testbench

//  VGA display end of the framebuffer read path: 640x480@60 timing generator that fetches a
//  256x256 8-bit grayscale image from RAM port B and drives the VGA DAC pins.

---
 rtl/vga_fb_scanout_pkg.sv | 37 +++
 rtl/vga_fb_scanout_if.sv | 12 +
 rtl/vga_fb_scanout_timing_gen.sv | 56 +++++
 rtl/vga_fb_scanout.sv | 138 +++++++++++++
 tb/tb_vga_fb_scanout.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_scanout_pkg.sv
// Shared VGA timing defaults and types for the framebuffer scanout path.
// 640x480@60 defaults; H_TOTAL/V_TOTAL and sync bounds are derived from these.
package vga_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;
  localparam int CNT_W            = 12;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic win;
    logic border;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, win: 1'b0, border: 1'b0};

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer RAM port-B read bus: the scanout drives address/enable, the RAM returns data.
interface vga_fb_scanout_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_rd_en, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd_en, output mem_rdata);
endinterface

// File: rtl/vga_fb_scanout_timing_gen.sv
// Horizontal/vertical counters with raw (undelayed) sync, active-area and frame-start decode.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             active,
  output logic             frame_start
);
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  logic [CNT_W-1:0] h_next, v_next;

  always_comb begin
    h_next = h + 1'b1;
    v_next = v;
    if (h == CNT_W'(H_TOTAL - 1)) begin
      h_next = '0;
      v_next = (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end
  end

  // frame_start is registered from the next-state decode so it stays low out of reset
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      h           <= h_next;
      v           <= v_next;
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

  assign hsync_raw = !((h >= CNT_W'(H_SYNC_START)) && (h <= CNT_W'(H_SYNC_END)));
  assign vsync_raw = !((v >= CNT_W'(V_SYNC_START)) && (v <= CNT_W'(V_SYNC_END)));
  assign active    = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA scanout: fetches a centred grayscale image from framebuffer port B and drives the DAC pins.
// Optional VGA_BORDER_EN macro paints a BORDER_RGB frame of BORDER_W pixels around the image.
module vga_fb_scanout import vga_pkg::*; #(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          IMG_X0     = 192,
  parameter int          IMG_Y0     = 112,
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 32,
  parameter int          RD_LAT     = 1,
  parameter int          BORDER_W   = 4,
  parameter logic [23:0] BORDER_RGB = 24'hFF0000
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic                    enable,
  vga_fb_scanout_if.master        mem,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_blank_n,
  output logic                    vga_sync_n,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    frame_start
);
  // Control delay ahead of the pin registers; pins add one more stage for L = RD_LAT + 2.
  localparam int STAGES = RD_LAT + 1;
`ifdef VGA_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic [CNT_W-1:0]  h, v;
  logic              hsync_raw, vsync_raw, active;
  logic              frame_en, img_rect, bord_rect, win, border;
  logic [ADDR_W-1:0] addr;
  ctrl_t             ctrl_p0, ctrl_last;
  ctrl_t             dly_p [STAGES];
  rgb_t              pix;
  logic              unused_rdata_hi;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .h          (h),
    .v          (v),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .active     (active),
    .frame_start(frame_start)
  );

  assign img_rect  = (h >= CNT_W'(IMG_X0)) && (h <= CNT_W'(IMG_X0 + IMG_W - 1)) &&
                     (v >= CNT_W'(IMG_Y0)) && (v <= CNT_W'(IMG_Y0 + IMG_H - 1));
  assign bord_rect = (h >= CNT_W'(IMG_X0 - BORDER_W)) && (h <= CNT_W'(IMG_X0 + IMG_W - 1 + BORDER_W)) &&
                     (v >= CNT_W'(IMG_Y0 - BORDER_W)) && (v <= CNT_W'(IMG_Y0 + IMG_H - 1 + BORDER_W));
  assign win       = img_rect && frame_en;
  // Border ring is geometric only, so it stays visible while the image is disabled
  assign border    = BORDER_ON && bord_rect && !img_rect && active;

  assign ctrl_p0 = '{hsync: hsync_raw, vsync: vsync_raw, blank_n: active, win: win, border: border};

  // Stage p0 -> p1: frame-enable latch, linear address counter, RAM request
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_en      <= 1'b0;
      addr          <= '0;
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= 1'b0;
    end else begin
      if ((h == '0) && (v == '0)) begin
        frame_en <= enable;
        addr     <= '0;
      end else if (win) begin
        addr <= addr + 1'b1;
      end
      mem.mem_addr  <= addr;
      mem.mem_rd_en <= win;
    end
  end

  // Stages p1..pSTAGES: control travels alongside the RAM read
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) dly_p[i] <= CTRL_IDLE;
    end else begin
      dly_p[0] <= ctrl_p0;
      for (int i = 1; i < STAGES; i++) dly_p[i] <= dly_p[i-1];
    end
  end

  assign ctrl_last       = dly_p[STAGES-1];
  assign unused_rdata_hi = ^mem.mem_rdata[DATA_W-1:8];

  always_comb begin
    pix = '0;
    if (ctrl_last.win) begin
      pix = '{r: mem.mem_rdata[7:0], g: mem.mem_rdata[7:0], b: mem.mem_rdata[7:0]};
    end else if (ctrl_last.border) begin
      pix = BORDER_RGB;
    end
  end

  // Output stage: pin registers
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hsync   <= ctrl_last.hsync;
      vga_vsync   <= ctrl_last.vsync;
      vga_blank_n <= ctrl_last.blank_n;
      vga_r       <= pix.r;
      vga_g       <= pix.g;
      vga_b       <= pix.b;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a reduced 80x55 raster with a 16x16 image at (24,16).
module tb_vga_fb_scanout;
  localparam int LINE  = 80;
  localparam int FRAME = 4400;
  localparam int L     = 3;
`ifdef VGA_BORDER_EN
  localparam logic [23:0] BCOL = 24'hFF0000;
`else
  localparam logic [23:0] BCOL = 24'h000000;
`endif

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b1;
  logic       hs, vs, bn, sn, fs;
  logic [7:0] r, g, b;

  vga_fb_scanout_if #(.ADDR_W(16), .DATA_W(32)) mem_bus ();

  vga_fb_scanout #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(16), .IMG_H(16), .IMG_X0(24), .IMG_Y0(16),
    .ADDR_W(16), .DATA_W(32), .RD_LAT(1), .BORDER_W(4), .BORDER_RGB(24'hFF0000)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .enable     (enable),
    .mem        (mem_bus.master),
    .vga_hsync  (hs),
    .vga_vsync  (vs),
    .vga_blank_n(bn),
    .vga_sync_n (sn),
    .vga_r      (r),
    .vga_g      (g),
    .vga_b      (b),
    .frame_start(fs)
  );

  always #20 vga_clk = ~vga_clk;

  // One-cycle-latency RAM returning its own address
  always @(posedge vga_clk) mem_bus.mem_rdata <= {16'h0, mem_bus.mem_addr};

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  typedef struct {
    int          fr;
    int          x;
    int          y;
    logic        bn;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    string       nm;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the falling edge inside cycle tgt (cycle 0 = first cycle after reset)
  task automatic goto(input int tgt);
    if (cur < tgt) begin
      while (cur < tgt) begin
        @(posedge vga_clk);
        cur++;
      end
      @(negedge vga_clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_hsync"}, {31'b0, hs}, 32'd1);
    chk({tag, "_vsync"}, {31'b0, vs}, 32'd1);
    chk({tag, "_blank_n"}, {31'b0, bn}, 32'd0);
    chk({tag, "_rgb"}, {8'b0, r, g, b}, 32'd0);
    chk({tag, "_frame_start"}, {31'b0, fs}, 32'd0);
    chk({tag, "_rd_en"}, {31'b0, mem_bus.mem_rd_en}, 32'd0);
    chk({tag, "_addr"}, {16'b0, mem_bus.mem_addr}, 32'd0);
    chk({tag, "_sync_n"}, {31'b0, sn}, 32'd0);
  endtask

  task automatic check_hsync_fall(input string tag);
    int n = 0;
    int start;
    while (hs !== 1'b0 && n < 200) begin goto(cur + 1); n++; end
    chk({tag, "_hs_fall"}, cur, 71);
    start = cur;
    n = 0;
    while (hs === 1'b0 && n < 200) begin goto(cur + 1); n++; end
    chk({tag, "_hs_width"}, cur - start, 8);
  endtask

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, bn_cnt, vs_cnt;

    vt[0]  = '{1, 64, 10, 1'b0, 1'b1, 1'b1, 24'h000000, "blank_h64"};
    vt[1]  = '{1, 67, 10, 1'b0, 1'b1, 1'b1, 24'h000000, "pre_hsync"};
    vt[2]  = '{1, 68, 10, 1'b0, 1'b0, 1'b1, 24'h000000, "hsync_first"};
    vt[3]  = '{1, 75, 10, 1'b0, 1'b0, 1'b1, 24'h000000, "hsync_last"};
    vt[4]  = '{1, 76, 10, 1'b0, 1'b1, 1'b1, 24'h000000, "post_hsync"};
    vt[5]  = '{1, 24, 11, 1'b1, 1'b1, 1'b1, 24'h000000, "above_border"};
    vt[6]  = '{1, 24, 12, 1'b1, 1'b1, 1'b1, BCOL,       "border_top"};
    vt[7]  = '{1, 10, 16, 1'b1, 1'b1, 1'b1, 24'h000000, "far_left"};
    vt[8]  = '{1, 23, 16, 1'b1, 1'b1, 1'b1, BCOL,       "border_left"};
    vt[9]  = '{1, 24, 16, 1'b1, 1'b1, 1'b1, 24'h000000, "img_first"};
    vt[10] = '{1, 25, 16, 1'b1, 1'b1, 1'b1, 24'h010101, "img_second"};
    vt[11] = '{1, 26, 17, 1'b1, 1'b1, 1'b1, 24'h121212, "img_row1"};
    vt[12] = '{1, 39, 31, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, "img_last"};
    vt[13] = '{1, 40, 31, 1'b1, 1'b1, 1'b1, BCOL,       "border_right"};
    vt[14] = '{1, 63, 47, 1'b1, 1'b1, 1'b1, 24'h000000, "last_active"};
    vt[15] = '{1, 79, 49, 1'b0, 1'b1, 1'b1, 24'h000000, "pre_vsync"};
    vt[16] = '{1, 0,  50, 1'b0, 1'b1, 1'b0, 24'h000000, "vsync_l50"};
    vt[17] = '{1, 0,  51, 1'b0, 1'b1, 1'b0, 24'h000000, "vsync_l51"};
    vt[18] = '{1, 0,  52, 1'b0, 1'b1, 1'b1, 24'h000000, "post_vsync"};

    // Initial reset, then reset-state outputs in cycle 0
    repeat (3) @(posedge vga_clk);
    cur = 0;
    @(negedge vga_clk);
    check_reset_state("por");
    reset = 1'b0;

    check_hsync_fall("por");
    goto(150);
    chk("hs_before_2nd_fall", {31'b0, hs}, 32'd1);
    goto(151);
    chk("hs_2nd_fall", {31'b0, hs}, 32'd0);

    goto(FRAME - 1);
    chk("fs_before", {31'b0, fs}, 32'd0);
    goto(FRAME);
    chk("fs_pulse", {31'b0, fs}, 32'd1);
    goto(FRAME + 1);
    chk("fs_after", {31'b0, fs}, 32'd0);

    foreach (vt[i]) begin
      goto(vt[i].fr * FRAME + vt[i].y * LINE + vt[i].x + L);
      chk({vt[i].nm, "_sync"}, {29'b0, bn, hs, vs}, {29'b0, vt[i].bn, vt[i].hs, vt[i].vs});
      chk({vt[i].nm, "_rgb"}, {8'b0, r, g, b}, {8'b0, vt[i].rgb});
    end

    // Frame 2: whole-frame counts; enable drops at line 20 but this frame keeps the image
    rd_cnt = 0; bn_cnt = 0; vs_cnt = 0;
    for (int c = 2 * FRAME; c < 3 * FRAME; c++) begin
      goto(c);
      if (mem_bus.mem_rd_en === 1'b1) rd_cnt++;
      if (bn === 1'b1) bn_cnt++;
      if (vs === 1'b0) vs_cnt++;
      if (c == 2 * FRAME) chk("fs_frame2", {31'b0, fs}, 32'd1);
      if (c == 2 * FRAME + 31 * LINE + 39 + L) chk("f2_img_last", {8'b0, r, g, b}, 32'hFFFFFF);
      if (c == 2 * FRAME + 20 * LINE) enable = 1'b0;
    end
    chk("f2_rd_en_count", rd_cnt, 256);
    chk("f2_blank_n_count", bn_cnt, 64 * 48);
    chk("f2_vsync_low_count", vs_cnt, 2 * LINE);

    // Frame 3: disabled, image area black, border unaffected; re-enable mid-frame
    rd_cnt = 0;
    for (int c = 3 * FRAME; c < 4 * FRAME; c++) begin
      goto(c);
      if (mem_bus.mem_rd_en === 1'b1) rd_cnt++;
      if (c == 3 * FRAME + 16 * LINE + 23 + L) chk("f3_border_left", {8'b0, r, g, b}, {8'b0, BCOL});
      if (c == 3 * FRAME + 16 * LINE + 25 + L) chk("f3_img_black", {8'b0, r, g, b}, 32'd0);
      if (c == 3 * FRAME + 30 * LINE) enable = 1'b1;
    end
    chk("f3_rd_en_count", rd_cnt, 0);

    // Frame 4: image restored
    goto(4 * FRAME + 16 * LINE + 25 + L);
    chk("f4_img_second", {8'b0, r, g, b}, 32'h010101);
    goto(4 * FRAME + 31 * LINE + 39 + L);
    chk("f4_img_last", {8'b0, r, g, b}, 32'hFFFFFF);

    // One-cycle reset in the middle of an hsync pulse
    goto(4 * FRAME + 32 * LINE + 72);
    chk("pre_reset_hs_low", {31'b0, hs}, 32'd0);
    reset = 1'b1;
    @(posedge vga_clk);
    cur = 0;
    @(negedge vga_clk);
    check_reset_state("mid");
    reset = 1'b0;
    check_hsync_fall("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
